if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage with an internal instruction memory, a decoupled prefetch queue and flush-on-redirect. It supersedes the single-register PC/instruction path in the IF stage. The unit fetches ahead of decode into a QUEUE_DEPTH-entry FIFO, presents {pc, instruction} to `if_id_reg` through a valid/ready handshake, and accepts UART programming of the instruction half of the upload space.

---
 rtl/if_prefetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_if_prefetch_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: IF stage with instruction memory, prefetch FIFO and
// flush-on-redirect. Optional perf counters under IF_PREFETCH_PERF_EN.
module if_prefetch_unit #(
  parameter int ISA_WIDTH   = 32,
  parameter int ROM_DEPTH   = 14,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_disable,
  input  logic                 uart_wen,
  input  logic [ROM_DEPTH:0]   uart_addr,
  input  logic [ISA_WIDTH-1:0] uart_data,
  input  logic                 redirect_valid,
  input  logic [1:0]           redirect_mode,
  input  logic [ISA_WIDTH-1:0] redirect_pc,
  input  logic [ISA_WIDTH-1:0] redirect_value,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [ISA_WIDTH-1:0] out_pc,
  output logic [ISA_WIDTH-1:0] out_instruction,
  output logic [ISA_WIDTH-1:0] fetch_pc,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_flush_cnt
);

  localparam int PW    = $clog2(QUEUE_DEPTH);
  localparam int CW    = PW + 1;
  localparam int WORDS = 1 << ROM_DEPTH;
  localparam logic [CW:0] QD = (CW+1)'(QUEUE_DEPTH);

  logic [ISA_WIDTH-1:0] mem [WORDS];
  logic [ISA_WIDTH-1:0] rdata_q;
  logic [ISA_WIDTH-1:0] q_pc  [QUEUE_DEPTH];
  logic [ISA_WIDTH-1:0] q_ins [QUEUE_DEPTH];

  logic [ISA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ISA_WIDTH-1:0] ipc_q, ipc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic                 infl_q, infl_d;
  logic                 iep_q, iep_d;
  logic                 epoch_q, epoch_d;

  logic                 redir;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 mem_we;
  logic [CW:0]          occ;
  logic [ISA_WIDTH-1:0] target;
  logic [ROM_DEPTH-1:0] raddr;

  assign redir  = redirect_valid & (redirect_mode != 2'b00);
  assign occ    = {1'b0, count_q} + (CW+1)'(infl_q);
  assign issue  = uart_disable & ~redir & (occ < QD);
  assign push   = uart_disable & ~redir & infl_q
                & (iep_q == epoch_q);
  assign pop    = out_valid & out_ready & ~redir;
  assign raddr  = fetch_pc_q[ROM_DEPTH+1:2];
  assign mem_we = ~uart_disable & uart_wen
                & ~uart_addr[ROM_DEPTH];

  assign out_valid       = (count_q != '0);
  assign out_pc          = out_valid ? q_pc[head_q]  : '0;
  assign out_instruction = out_valid ? q_ins[head_q] : '0;
  assign fetch_pc        = fetch_pc_q;

  // redirect target decode
  always_comb begin
    target = '0;
    unique case (1'b1)
      (redirect_mode == 2'b01):
        target = redirect_pc + (redirect_value << 2);
      (redirect_mode == 2'b10):
        target = redirect_value;
      default:
        target = '0;
    endcase
  end

  // queue / fetch next-state; redirect beats upload beats normal flow
  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fetch_pc_d = fetch_pc_q;
    infl_d     = 1'b0;
    ipc_d      = ipc_q;
    iep_d      = iep_q;
    epoch_d    = epoch_q;
    if (redir) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      epoch_d    = ~epoch_q;
      fetch_pc_d = target;
    end else if (!uart_disable) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (issue) begin
        infl_d     = 1'b1;
        ipc_d      = fetch_pc_q;
        iep_d      = epoch_q;
        fetch_pc_d = fetch_pc_q + ISA_WIDTH'(4);
      end
    end
  end

  // control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fetch_pc_q <= '0;
      infl_q     <= 1'b0;
      ipc_q      <= '0;
      iep_q      <= 1'b0;
      epoch_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fetch_pc_q <= fetch_pc_d;
      infl_q     <= infl_d;
      ipc_q      <= ipc_d;
      iep_q      <= iep_d;
      epoch_q    <= epoch_d;
    end
  end

  // instruction memory: UART write port, synchronous read
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[uart_addr[ROM_DEPTH-1:0]] <= uart_data;
    if (issue)
      rdata_q <= mem[raddr];
  end

  // queue payload storage, validity tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail_q]  <= ipc_q;
      q_ins[tail_q] <= rdata_q;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        flush_hit;

  assign flush_hit = redir & ((count_q != '0) | infl_q);

  // saturating counter next-state
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pop && (fetch_cnt_q != '1))
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (flush_hit && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: vector table, hand sequences and a random
// run compared against a queue-level reference model.
`timescale 1ns/1ps
module tb_if_prefetch_unit;

  localparam int W  = 32;
  localparam int RD = 14;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_disable;
  logic          uart_wen;
  logic [RD:0]   uart_addr;
  logic [W-1:0]  uart_data;
  logic          redirect_valid;
  logic [1:0]    redirect_mode;
  logic [W-1:0]  redirect_pc;
  logic [W-1:0]  redirect_value;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  out_pc;
  logic [W-1:0]  out_instruction;
  logic [W-1:0]  fetch_pc;
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_flush_cnt;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .ISA_WIDTH(W), .ROM_DEPTH(RD), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_disable(uart_disable), .uart_wen(uart_wen),
    .uart_addr(uart_addr), .uart_data(uart_data),
    .redirect_valid(redirect_valid),
    .redirect_mode(redirect_mode),
    .redirect_pc(redirect_pc),
    .redirect_value(redirect_value),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_instruction(out_instruction),
    .fetch_pc(fetch_pc),
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  // reference model: queue of delivered words, one pending read
  ent_t        mq[$];
  logic [31:0] mm [1<<RD];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fpc;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  typedef struct {
    logic        ud;
    logic        rdy;
    logic        rv;
    logic [1:0]  mode;
    logic [31:0] rval;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    logic [31:0] efpc;
  } vec_t;

  vec_t tv [14];

  function automatic logic [31:0] init_word(int a);
    if (a < 4) return 32'h11 * (a + 1);
    return (32'h9E3779B9 * a) ^ 32'h5A5A0000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pend  = 1'b0;
    m_fpc   = '0;
    m_fetch = '0;
    m_flush = '0;
  endtask

  task automatic model_edge();
    int sz;
    bit pend;
    bit redir;
    sz    = mq.size();
    pend  = m_pend;
    redir = redirect_valid && (redirect_mode != 2'b00);
    if (redir) begin
      if ((sz > 0 || pend) && m_flush != 32'hFFFF_FFFF)
        m_flush++;
      mq.delete();
      m_pend = 1'b0;
      case (redirect_mode)
        2'b01:   m_fpc = redirect_pc + (redirect_value * 4);
        2'b10:   m_fpc = redirect_value;
        default: m_fpc = 32'd0;
      endcase
    end else if (!uart_disable) begin
      mq.delete();
      m_pend = 1'b0;
    end else begin
      if (sz > 0 && out_ready) begin
        void'(mq.pop_front());
        if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
      end
      if (pend)
        mq.push_back('{m_pend_pc,
                       mm[(m_pend_pc / 4) % (1 << RD)]});
      if (sz + int'(pend) < QD) begin
        m_pend    = 1'b1;
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
    if (!uart_disable && uart_wen && !uart_addr[RD])
      mm[uart_addr[RD-1:0]] = uart_data;
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_model(string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk({tag, "_pc"}, out_pc, mq[0].pc);
      chk({tag, "_ins"}, out_instruction, mq[0].ins);
    end
    chk({tag, "_fpc"}, fetch_pc, m_fpc);
`ifdef IF_PREFETCH_PERF_EN
    chk({tag, "_pfetch"}, perf_fetch_cnt, m_fetch);
    chk({tag, "_pflush"}, perf_flush_cnt, m_flush);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    uart_wen       = 1'b0;
    uart_addr      = '0;
    uart_data      = '0;
    redirect_valid = 1'b0;
    redirect_mode  = 2'b00;
    redirect_pc    = '0;
    redirect_value = '0;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'd0,
               1'b0, 32'd0, 32'd0, 32'h4};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h0, 32'h11, 32'h8};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h4, 32'h22, 32'hC};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h8, 32'h33, 32'h10};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'd0,
               1'b1, 32'hC, 32'h44, 32'h14};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h10000,
               1'b0, 32'd0, 32'd0, 32'h10000};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0,
               1'b0, 32'd0, 32'd0, 32'h10004};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h10000, 32'h11, 32'h10008};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h10000, 32'h11, 32'h1000C};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h10000, 32'h11, 32'h10010};
    tv[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h10000, 32'h11, 32'h10010};
    tv[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h10000, 32'h11, 32'h10010};
    tv[12] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h10004, 32'h22, 32'h10010};
    tv[13] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'd0,
               1'b1, 32'h10008, 32'h33, 32'h10014};

    idle_in();
    uart_disable = 1'b0;
    out_ready    = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_ins", out_instruction, 32'd0);
    chk("rst_fpc", fetch_pc, 32'd0);
    rst_n = 1'b1;

    // upload the whole instruction memory
    for (int a = 0; a < (1 << RD); a++) begin
      uart_wen  = 1'b1;
      uart_addr = (RD+1)'(a);
      uart_data = init_word(a);
      tick();
    end
    idle_in();
    tick();
    cmp_model("upload");

    // vector table: first fetch, streaming, wrap, fill
    for (int i = 0; i < 14; i++) begin
      uart_disable   = tv[i].ud;
      out_ready      = tv[i].rdy;
      redirect_valid = tv[i].rv;
      redirect_mode  = tv[i].mode;
      redirect_value = tv[i].rval;
      redirect_pc    = '0;
      tick();
      chk($sformatf("vec%0d_valid", i),
          32'(out_valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("vec%0d_pc", i), out_pc, tv[i].epc);
        chk($sformatf("vec%0d_ins", i),
            out_instruction, tv[i].eins);
      end
      chk($sformatf("vec%0d_fpc", i), fetch_pc, tv[i].efpc);
    end
    idle_in();

    // stall for 10 cycles from pc 0
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_mode  = 2'b11;
    tick();
    idle_in();
    for (int i = 0; i < 10; i++) tick();
    chk("stall_fpc", fetch_pc, 32'h10);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_pc", out_pc, 32'h0);
    chk("stall_ins", out_instruction, 32'h11);
    cmp_model("stall");

    // relative redirect with 3 queued + 1 in flight
    redirect_valid = 1'b1;
    redirect_mode  = 2'b11;
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) tick();
    chk("rel_pre_fpc", fetch_pc, 32'h10);
    redirect_valid = 1'b1;
    redirect_mode  = 2'b01;
    redirect_pc    = 32'h8;
    redirect_value = 32'd3;
    tick();
    idle_in();
    chk("rel_e0_valid", 32'(out_valid), 32'd0);
    chk("rel_e0_fpc", fetch_pc, 32'h14);
    tick();
    chk("rel_e1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("rel_e2_valid", 32'(out_valid), 32'd1);
    chk("rel_e2_pc", out_pc, 32'h14);
    chk("rel_e2_ins", out_instruction, init_word(5));
    cmp_model("rel");

    // data-space UART write must not touch word 0
    uart_disable = 1'b0;
    uart_wen     = 1'b1;
    uart_addr    = {1'b1, 14'd0};
    uart_data    = 32'hDEADBEEF;
    tick();
    idle_in();
    redirect_valid = 1'b1;
    redirect_mode  = 2'b11;
    tick();
    idle_in();
    chk("upl_valid", 32'(out_valid), 32'd0);
    uart_disable = 1'b1;
    tick();
    tick();
    chk("msb_pc", out_pc, 32'h0);
    chk("msb_ins", out_instruction, 32'h11);

    // asynchronous reset with a full queue
    for (int i = 0; i < 6; i++) tick();
    chk("full_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_fpc", fetch_pc, 32'd0);
    chk("arst_pc", out_pc, 32'd0);
`ifdef IF_PREFETCH_PERF_EN
    chk("arst_pfetch", perf_fetch_cnt, 32'd0);
    chk("arst_pflush", perf_flush_cnt, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rel1_valid", 32'(out_valid), 32'd0);
    chk("rel1_fpc", fetch_pc, 32'h4);
    tick();
    chk("rel2_valid", 32'(out_valid), 32'd1);
    chk("rel2_pc", out_pc, 32'h0);
    chk("rel2_ins", out_instruction, 32'h11);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle_in();
      if ($urandom_range(0, 49) == 0)
        uart_disable = ~uart_disable;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!uart_disable && $urandom_range(0, 1) == 1) begin
        uart_wen  = 1'b1;
        uart_addr = (RD+1)'($urandom);
        uart_data = $urandom;
      end
      if ($urandom_range(0, 9) == 0) begin
        redirect_valid = 1'b1;
        redirect_mode  = 2'($urandom_range(0, 3));
        redirect_pc    = $urandom;
        if (redirect_mode == 2'b01)
          redirect_value = $urandom_range(0, 255);
        else
          redirect_value = $urandom;
      end
      tick();
      cmp_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
